// File: rtl/gate_share_arbiter_pkg.sv
// Shared opcode and FSM encodings for the gate-sharing arbiter.
// Imported by the interface, the logic unit and the arbiter top.
package gate_share_arbiter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOT = 2'b00,
    OP_OR  = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/gate_share_arbiter_if.sv
// Request/grant/result bundle between client blocks and the arbiter.
// Clients drive the master side; the arbiter takes the slave side.
interface gate_share_arbiter_if
  import gate_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 1
);

  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]      req;
  logic [OP_W*N_REQ-1:0] op;
  logic [W*N_REQ-1:0]    a;
  logic [W*N_REQ-1:0]    b;
  logic [N_REQ-1:0]      gnt;
  logic                  busy;
  logic [W-1:0]          res;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;

  modport master (
    output req, op, a, b,
    input  gnt, busy, res, res_valid, res_id
  );

  modport slave (
    input  req, op, a, b,
    output gnt, busy, res, res_valid, res_id
  );

endinterface

// File: rtl/gate_share_arbiter_unit.sv
// Shared combinational bitwise logic unit (NOT/OR/AND/XOR).
// B is ignored for NOT.
module gate_share_unit
  import gate_share_arbiter_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [W-1:0]    i_a,
  input  logic [W-1:0]    i_b,
  output logic [W-1:0]    o_y
);

  always_comb begin
    o_y = '0;
    unique case (op_e'(i_op))
      OP_NOT: o_y = ~i_a;
      OP_OR:  o_y = i_a | i_b;
      OP_AND: o_y = i_a & i_b;
      OP_XOR: o_y = i_a ^ i_b;
    endcase
  end

endmodule

// File: rtl/gate_share_arbiter.sv
// Round-robin arbiter time-sharing one logic unit among N_REQ clients.
// Grant in IDLE latches operands; EXEC registers the tagged result.
module gate_share_arbiter
  import gate_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 1
) (
  input  logic               clk,
  input  logic               rst,
  gate_share_arbiter_if.slave bus
);

  localparam int IDW = $clog2(N_REQ);

  state_e           r_state, w_state_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [IDW-1:0]   r_win, w_win_nxt;
  logic [OP_W-1:0]  r_op, w_op_nxt;
  logic [W-1:0]     r_a, w_a_nxt;
  logic [W-1:0]     r_b, w_b_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [W-1:0]     r_res, w_res_nxt;
  logic             r_rv, w_rv_nxt;
  logic [IDW-1:0]   r_id, w_id_nxt;

  logic             w_hit;
  logic [IDW-1:0]   w_sel;
  logic [IDW-1:0]   w_cand;
  int               w_j;
  logic [OP_W-1:0]  w_sel_op;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic [W-1:0]     w_y;

  // First requester at or after ptr, wrapping modulo N_REQ
  always_comb begin
    w_hit  = 1'b0;
    w_sel  = '0;
    w_cand = '0;
    w_j    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      w_cand = IDW'(w_j);
      if (!w_hit && bus.req[w_cand]) begin
        w_hit = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel == IDW'(i)) begin
        w_sel_op = bus.op[OP_W*i +: OP_W];
        w_sel_a  = bus.a[W*i +: W];
        w_sel_b  = bus.b[W*i +: W];
      end
    end
  end

  gate_share_unit #(.W(W)) u_unit (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_gnt_nxt   = '0;
    w_res_nxt   = r_res;
    w_rv_nxt    = 1'b0;
    w_id_nxt    = r_id;
    unique case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state_nxt = ST_EXEC;
          w_win_nxt   = w_sel;
          w_op_nxt    = w_sel_op;
          w_a_nxt     = w_sel_a;
          w_b_nxt     = w_sel_b;
          w_gnt_nxt   = N_REQ'(1) << w_sel;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_IDLE;
        w_res_nxt   = w_y;
        w_rv_nxt    = 1'b1;
        w_id_nxt    = r_win;
        w_ptr_nxt   = (r_win == IDW'(N_REQ-1)) ? '0 : r_win + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_gnt   <= '0;
      r_res   <= '0;
      r_rv    <= 1'b0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_gnt   <= w_gnt_nxt;
      r_res   <= w_res_nxt;
      r_rv    <= w_rv_nxt;
      r_id    <= w_id_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = (r_state == ST_EXEC);
  assign bus.res       = r_res;
  assign bus.res_valid = r_rv;
  assign bus.res_id    = r_id;

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Randomized + directed bench for gate_share_arbiter.
// A transaction-level reference model predicts every output each cycle.
module tb_gate_share_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_share_arbiter_if #(.N_REQ(N), .W(W)) bus();

  gate_share_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: an operation is either in flight or not.
  bit         m_inflight;
  int         m_ptr;
  int         m_win;
  logic [1:0] m_op;
  logic [W-1:0] m_a, m_b;
  logic [N-1:0] e_gnt;
  logic       e_busy, e_rv;
  logic [W-1:0] e_res;
  int         e_id;

  function automatic logic [W-1:0] ref_f(logic [1:0] o,
                                         logic [W-1:0] x,
                                         logic [W-1:0] y);
    case (o)
      2'd0:    return ~x;
      2'd1:    return x | y;
      2'd2:    return x & y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic model_update();
    if (rst) begin
      m_inflight = 0; m_ptr = 0;
      e_gnt = '0; e_busy = 0; e_rv = 0; e_res = '0; e_id = 0;
    end else if (m_inflight) begin
      e_res = ref_f(m_op, m_a, m_b);
      e_rv = 1; e_id = m_win;
      m_ptr = (m_win + 1) % N;
      e_gnt = '0; e_busy = 0; m_inflight = 0;
    end else begin
      int w;
      e_rv = 0; e_gnt = '0; e_busy = 0;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_win = w;
        m_op = bus.op[2*w +: 2];
        m_a  = bus.a[W*w +: W];
        m_b  = bus.b[W*w +: W];
        e_gnt = N'(1) << w;
        e_busy = 1; m_inflight = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("res_valid", 32'(bus.res_valid), 32'(e_rv));
    chk("res", 32'(bus.res), 32'(e_res));
    chk("res_id", 32'(bus.res_id), 32'(e_id));
  endtask

  task automatic set_op(int i, logic [1:0] o, logic [W-1:0] av,
                        logic [W-1:0] bv);
    bus.op[2*i +: 2] = o;
    bus.a[W*i +: W]  = av;
    bus.b[W*i +: W]  = bv;
  endtask

  int g;

  initial begin
    rst = 1'b1;
    bus.req = '1;
    bus.op = '0; bus.a = '0; bus.b = '0;
    // reset with all requesting
    step(); step();
    rst = 1'b0;
    step();
    chk("first_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    step();
    chk("first_id", 32'(bus.res_id), 32'd0);
    // single OR from requester 2
    bus.req = 4'b0100;
    set_op(2, 2'b01, 4'b0000, 4'b0001);
    step();
    chk("or_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    step();
    chk("or_res", 32'(bus.res), 32'h1);
    chk("or_id", 32'(bus.res_id), 32'd2);
    // wrap fairness from ptr=3
    bus.req = 4'b0101;
    set_op(0, 2'b01, 4'h1, 4'h2);
    step();
    chk("wrap_gnt0", 32'(bus.gnt), 32'h1);
    step();
    step();
    chk("wrap_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    step();
    // NOT with b ignored
    bus.req = 4'b0001;
    set_op(0, 2'b00, 4'b1010, 4'b1111);
    step();
    bus.req = '0;
    step();
    chk("not_res", 32'(bus.res), 32'h5);
    // continuous AND, ptr now 1
    bus.req = '1;
    for (int i = 0; i < N; i++)
      set_op(i, 2'b10, W'(4'hF - i), W'(4'h3 + 3*i));
    g = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.gnt != '0) begin
        chk("rr_order", 32'(bus.gnt), 32'(1 << ((1 + g) % N)));
        g++;
      end
    end
    chk("rr_count", 32'(g), 32'd5);
    // reset during EXEC of an XOR
    bus.req = '0;
    step(); step();
    bus.req = 4'b0001;
    set_op(0, 2'b11, 4'hC, 4'hA);
    step();
    rst = 1'b1;
    bus.req = 4'b0010;
    step();
    chk("rst_exec_rv", 32'(bus.res_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_gnt", 32'(bus.gnt), 32'h2);
    step();
    // random traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.req = N'($urandom);
      bus.op = 8'($urandom);
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
